// File: rtl/stream_add_acc_pkg.sv
// Shared types and helpers for the streaming adder/accumulator.
package stream_add_pkg;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_ACC = 1'b1
  } mode_e;

  // Result width for a w-bit operand add: one carry bit on top.
  function automatic int unsigned RES_W(input int unsigned w);
    return w + 1;
  endfunction

  localparam int unsigned DEF_WIDTH = 4;

  // Output FIFO entry for the default operand width.
  typedef logic [RES_W(DEF_WIDTH)-1:0] fifo_entry_t;

endpackage

// File: rtl/stream_add_acc_if.sv
// Producer/consumer stream bundle for stream_add_acc, plus status outputs.
interface stream_add_acc_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 16
);
  import stream_add_pkg::*;

  logic                       in_valid;
  logic                       in_ready;
  logic [WIDTH-1:0]           a;
  logic [WIDTH-1:0]           b;
  logic                       mode;
  logic                       clr;
  logic                       out_valid;
  logic                       out_ready;
  logic [RES_W(WIDTH)-1:0]    y;
  logic                       ovf;
  logic [CNT_W-1:0]           txn_cnt;

  modport master (
    output in_valid, a, b, mode, clr, out_ready,
    input  in_ready, out_valid, y, ovf, txn_cnt
  );

  modport slave (
    input  in_valid, a, b, mode, clr, out_ready,
    output in_ready, out_valid, y, ovf, txn_cnt
  );

endinterface

// File: rtl/stream_add_acc_fifo.sv
// Single-clock FIFO with full/empty; head reads as zero when empty.
module sync_fifo
  import stream_add_pkg::*;
#(
  parameter int unsigned W     = RES_W(DEF_WIDTH),
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [W-1:0] o_dout,
  output logic         o_full,
  output logic         o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_cnt;
  logic          w_push;
  logic          w_pop;

  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_dout  = o_empty ? '0 : r_mem[r_rd];

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage write; contents need no reset since the head is masked when empty.
  always_ff @(posedge clk) begin
    if (rst_n && w_push) r_mem[r_wr] <= i_din;
  end

endmodule

// File: rtl/stream_add_acc.sv
// Streaming adder/accumulator with valid/ready on both sides and an output FIFO.
// Optional feature: STREAM_ADD_SAT_EN saturates ACC overflow instead of wrapping.
module stream_add_acc
  import stream_add_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input logic              clk,
  input logic              rst_n,
  stream_add_acc_if.slave  io_bus
);

  localparam int unsigned RW = RES_W(WIDTH);
  localparam int unsigned SW = WIDTH + 2;

  logic [RW-1:0]    r_acc;
  logic             r_ovf;
  logic [CNT_W-1:0] r_cnt;

  mode_e            w_mode;
  logic             w_full;
  logic             w_empty;
  logic             w_accept;
  logic             w_pop;
  logic [RW-1:0]    w_base;
  logic [SW-1:0]    w_sum;
  logic             w_of;
  logic [RW-1:0]    w_res;
  logic [RW-1:0]    w_acc_nxt;
  logic             w_ovf_nxt;
  logic [RW-1:0]    w_head;

  assign w_mode   = mode_e'(io_bus.mode);
  assign w_accept = io_bus.in_valid && !w_full;
  assign w_pop    = io_bus.out_ready && !w_empty;

  // Result and next accumulator/overflow state for the current cycle.
  always_comb begin
    w_base    = io_bus.clr ? '0 : r_acc;
    w_sum     = SW'(w_base) + SW'(io_bus.a) + SW'(io_bus.b);
    w_of      = 1'b0;
    w_res     = RW'(io_bus.a) + RW'(io_bus.b);
    w_acc_nxt = r_acc;
    w_ovf_nxt = r_ovf;
    if (w_mode == MODE_ACC) begin
      w_of = w_sum[SW-1];
`ifdef STREAM_ADD_SAT_EN
      w_res = w_of ? '1 : w_sum[RW-1:0];
`else
      w_res = w_sum[RW-1:0];
`endif
    end
    if (w_accept && (w_mode == MODE_ACC)) begin
      w_acc_nxt = w_res;
      w_ovf_nxt = io_bus.clr ? w_of : (r_ovf | w_of);
    end else if (io_bus.clr) begin
      w_acc_nxt = '0;
      w_ovf_nxt = 1'b0;
    end
  end

  // Accumulator, sticky overflow and accepted-beat counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_acc <= w_acc_nxt;
      r_ovf <= w_ovf_nxt;
      if (w_accept) r_cnt <= r_cnt + 1'b1;
    end
  end

  sync_fifo #(
    .W     (RW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_accept),
    .i_din   (w_res),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign io_bus.in_ready  = !w_full;
  assign io_bus.out_valid = !w_empty;
  assign io_bus.y         = w_head;
  assign io_bus.ovf       = r_ovf;
  assign io_bus.txn_cnt   = r_cnt;

endmodule

// File: tb/tb_stream_add_acc.sv
// Self-checking bench for stream_add_acc (WIDTH=4, DEPTH=4).
module tb_stream_add_acc;
  import stream_add_pkg::*;

  localparam int W    = 4;
  localparam int D    = 4;
  localparam int CW   = 16;
  localparam int MAXR = (1 << (W + 1)) - 1;
`ifdef STREAM_ADD_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    int a;
    int b;
    int mode;
    int clr;
    int ey;
    int eovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  stream_add_acc_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  stream_add_acc #(.WIDTH(W), .DEPTH(D), .CNT_W(CW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  int total = 0;
  int bad   = 0;

  int m_q[$];
  int m_acc;
  int m_ovf;
  int m_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input int v, input int a, input int b, input int md, input int cl);
    bus.in_valid = v[0];
    bus.a        = a[W-1:0];
    bus.b        = b[W-1:0];
    bus.mode     = md[0];
    bus.clr      = cl[0];
  endtask

  // One clock: advance the reference model from the inputs presented, then compare.
  task automatic cycle();
    bit acc, pop;
    int va, vb, md, cl, s, res, o;
    acc = rst_n && bus.in_valid && (m_q.size() < D);
    pop = rst_n && bus.out_ready && (m_q.size() > 0);
    va  = int'(bus.a);
    vb  = int'(bus.b);
    md  = int'(bus.mode);
    cl  = int'(bus.clr);
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m_q.delete();
      m_acc = 0;
      m_ovf = 0;
      m_cnt = 0;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (acc) begin
        m_cnt = (m_cnt + 1) % (1 << CW);
        if (md != 0) begin
          s   = (cl != 0 ? 0 : m_acc) + va + vb;
          o   = (s > MAXR) ? 1 : 0;
          res = (o != 0) ? (SAT ? MAXR : s % (MAXR + 1)) : s;
          m_acc = res;
          m_ovf = (cl != 0) ? o : (m_ovf | o);
        end else begin
          res = va + vb;
          if (cl != 0) begin
            m_acc = 0;
            m_ovf = 0;
          end
        end
        m_q.push_back(res);
      end else if (cl != 0) begin
        m_acc = 0;
        m_ovf = 0;
      end
    end
    chk("out_valid", bus.out_valid, (m_q.size() > 0) ? 1 : 0);
    chk("in_ready", bus.in_ready, (m_q.size() < D) ? 1 : 0);
    chk("y_head", bus.y, (m_q.size() > 0) ? m_q[0] : 0);
    chk("ovf", bus.ovf, m_ovf);
    chk("txn_cnt", bus.txn_cnt, m_cnt);
  endtask

  vec_t t2[4];
  vec_t t4[4];

  initial begin
    t2[0] = '{1, 3, 0, 0, 4, 0};
    t2[1] = '{5, 6, 0, 0, 11, 0};
    t2[2] = '{7, 8, 0, 0, 15, 0};
    t2[3] = '{15, 15, 0, 0, 30, 0};
    t4[0] = '{1, 3, 1, 0, 4, 0};
    t4[1] = '{5, 6, 1, 0, 15, 0};
    t4[2] = '{7, 8, 1, 0, 30, 0};
    t4[3] = '{15, 15, 1, 0, SAT ? 31 : 28, 1};

    rst_n = 1'b0;
    bus.out_ready = 1'b0;
    drive(0, 0, 0, 0, 0);
    cycle();
    cycle();
    rst_n = 1'b1;

    // ADD stream with a free-running consumer
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1, t2[i].a, t2[i].b, t2[i].mode, t2[i].clr);
      cycle();
      chk("t2_y", bus.y, t2[i].ey);
      chk("t2_ovf", bus.ovf, t2[i].eovf);
    end
    drive(0, 0, 0, 0, 0);
    chk("t2_cnt", bus.txn_cnt, 4);
    cycle();

    // clr alone, then an ACC run that overflows on the last beat
    drive(0, 0, 0, 0, 1);
    cycle();
    for (int i = 0; i < 4; i++) begin
      drive(1, t4[i].a, t4[i].b, t4[i].mode, t4[i].clr);
      cycle();
      chk("t4_y", bus.y, t4[i].ey);
      chk("t4_ovf", bus.ovf, t4[i].eovf);
    end
    drive(0, 0, 0, 0, 0);
    chk("t4_cnt", bus.txn_cnt, 8);
    cycle();

    // acc=30, then clr together with an ACC beat
    drive(1, 15, 15, 1, 1);
    cycle();
    chk("t5_acc30", bus.y, 30);
    drive(1, 2, 2, 1, 1);
    cycle();
    chk("t5_clr_acc_y", bus.y, 4);
    chk("t5_clr_acc_ovf", bus.ovf, 0);
    drive(1, 0, 0, 1, 0);
    cycle();
    chk("t5_next_y", bus.y, 4);
    drive(0, 0, 0, 0, 0);
    cycle();

    // backpressure: fill, refuse, then release
    bus.out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      drive(1, k, k + 1, 0, 0);
      cycle();
    end
    drive(1, 5, 6, 0, 0);
    chk("t3_full_ready", bus.in_ready, 0);
    chk("t3_cnt4", bus.txn_cnt, 15);
    chk("t3_head", bus.y, 3);
    cycle();
    chk("t3_refused", bus.txn_cnt, 15);
    bus.out_ready = 1'b1;
    cycle();
    chk("t3_pop_no_accept", bus.txn_cnt, 15);
    chk("t3_ready_after_pop", bus.in_ready, 1);
    chk("t3_head2", bus.y, 5);
    cycle();
    chk("t3_fifth_accept", bus.txn_cnt, 16);
    chk("t3_head3", bus.y, 7);
    drive(0, 0, 0, 0, 0);
    cycle();
    chk("t3_head4", bus.y, 9);
    cycle();
    chk("t3_head5", bus.y, 11);
    cycle();
    cycle();

    // reset mid-stream with ovf set
    drive(1, 15, 15, 1, 0);
    cycle();
    cycle();
    chk("t1_ovf_pre", bus.ovf, 1);
    rst_n = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0);
    cycle();
    chk("t1_out_valid", bus.out_valid, 0);
    chk("t1_in_ready", bus.in_ready, 1);
    chk("t1_ovf", bus.ovf, 0);
    chk("t1_cnt", bus.txn_cnt, 0);

    // reset with 3 queued entries and acc=9
    bus.out_ready = 1'b0;
    drive(1, 4, 5, 1, 1);
    cycle();
    drive(1, 1, 1, 0, 0);
    cycle();
    drive(1, 2, 2, 0, 0);
    cycle();
    drive(0, 0, 0, 0, 0);
    chk("t6_pre_cnt", bus.txn_cnt, 3);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    chk("t6_out_valid", bus.out_valid, 0);
    chk("t6_cnt", bus.txn_cnt, 0);
    bus.out_ready = 1'b1;
    drive(1, 1, 1, 1, 0);
    cycle();
    chk("t6_acc_zero", bus.y, 2);
    drive(0, 0, 0, 0, 0);
    cycle();

    // randomized traffic against the reference model
    for (int n = 0; n < 800; n++) begin
      rst_n = ($urandom_range(0, 149) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      drive(($urandom_range(0, 3) != 0) ? 1 : 0, $urandom_range(0, 15), $urandom_range(0, 15),
            $urandom_range(0, 1), ($urandom_range(0, 9) == 0) ? 1 : 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
